// File: rtl/mux_arb_n_to_1.sv
// mux_arb_n_to_1: M-input, N-bit selector with valid/ready handshakes on
// every input and a single registered output slot.
// mode=0 picks channel `sel`; mode=1 round-robins among valid channels.
// Optional feature macro: MUX_ARB_STATS_EN adds per-channel saturating
// 16-bit transfer counters on the xfer_cnt port.
module mux_arb_n_to_1 #(
    parameter int N = 32,
    parameter int M = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [$clog2(M)-1:0] sel,
    input  logic [M*N-1:0]       in_data,
    input  logic [M-1:0]         in_valid,
    output logic [M-1:0]         in_ready,
    output logic [N-1:0]         out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(M)-1:0] out_src
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [M*16-1:0]      xfer_cnt
`endif
);

    localparam int SEL_W = $clog2(M);

    logic [N-1:0]     r_out_data;
    logic [SEL_W-1:0] r_out_src;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_rr_ptr;

    logic             w_accept;
    logic [SEL_W-1:0] w_grant;
    logic             w_grant_valid;
    logic [N-1:0]     w_grant_data;
    logic             w_hi_found;
    logic [SEL_W-1:0] w_hi_idx;
    logic             w_lo_found;
    logic [SEL_W-1:0] w_lo_idx;

    // The single output slot can take a new beat when empty or draining this cycle.
    assign w_accept = ~r_out_valid | out_ready;

    // Grant selection; round-robin takes the first valid channel above rr_ptr, else wraps to the lowest valid one.
    always_comb begin
        w_grant       = '0;
        w_grant_valid = 1'b0;
        w_hi_found    = 1'b0;
        w_hi_idx      = '0;
        w_lo_found    = 1'b0;
        w_lo_idx      = '0;
        for (int k = 0; k < M; k++) begin
            if (in_valid[k]) begin
                if (!w_lo_found) begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = SEL_W'(k);
                end
                if (!w_hi_found && (SEL_W'(k) > r_rr_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = SEL_W'(k);
                end
            end
        end
        if (mode) begin
            if (w_hi_found) begin
                w_grant       = w_hi_idx;
                w_grant_valid = 1'b1;
            end else if (w_lo_found) begin
                w_grant       = w_lo_idx;
                w_grant_valid = 1'b1;
            end
        end else begin
            // An out-of-range sel matches no channel, so it never grants.
            for (int k = 0; k < M; k++) begin
                if ((sel == SEL_W'(k)) && in_valid[k]) begin
                    w_grant       = SEL_W'(k);
                    w_grant_valid = 1'b1;
                end
            end
        end
    end

    // Data mux for the granted channel.
    always_comb begin
        w_grant_data = '0;
        for (int k = 0; k < M; k++) begin
            if (w_grant == SEL_W'(k)) begin
                w_grant_data = in_data[k*N +: N];
            end
        end
    end

    // One-hot ready toward the granted producer; forced low during reset.
    always_comb begin
        in_ready = '0;
        for (int k = 0; k < M; k++) begin
            in_ready[k] = ~rst & w_accept & w_grant_valid & (w_grant == SEL_W'(k));
        end
    end

    // Output slot and round-robin pointer; the slot holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_rr_ptr    <= SEL_W'(M - 1);
        end else if (w_accept) begin
            if (w_grant_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_grant_data;
                r_out_src   <= w_grant;
                if (mode) begin
                    r_rr_ptr <= w_grant;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_src   = r_out_src;

`ifdef MUX_ARB_STATS_EN
    logic [15:0] r_xfer_cnt [M];

    // Per-channel transfer counters that stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < M; k++) begin
                r_xfer_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < M; k++) begin
                if (in_ready[k] && (r_xfer_cnt[k] != 16'hFFFF)) begin
                    r_xfer_cnt[k] <= r_xfer_cnt[k] + 16'd1;
                end
            end
        end
    end

    // Flatten the counters onto the port.
    always_comb begin
        xfer_cnt = '0;
        for (int k = 0; k < M; k++) begin
            xfer_cnt[k*16 +: 16] = r_xfer_cnt[k];
        end
    end
`endif

endmodule

// File: tb/tb_mux_arb_n_to_1.sv
// Directed bench for mux_arb_n_to_1: a 4-input 32-bit instance and a
// 3-input 8-bit instance. Stats checks are built when MUX_ARB_STATS_EN is set.
module tb_mux_arb_n_to_1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // 4-input, 32-bit instance
    logic         rst4, mode4, oready4;
    logic [1:0]   sel4;
    logic [127:0] idata4;
    logic [3:0]   ivalid4, iready4;
    logic [31:0]  odata4;
    logic         ovalid4;
    logic [1:0]   osrc4;
`ifdef MUX_ARB_STATS_EN
    logic [63:0]  xcnt4;
`endif

    // 3-input, 8-bit instance
    logic         rst3, mode3, oready3;
    logic [1:0]   sel3;
    logic [23:0]  idata3;
    logic [2:0]   ivalid3, iready3;
    logic [7:0]   odata3;
    logic         ovalid3;
    logic [1:0]   osrc3;
`ifdef MUX_ARB_STATS_EN
    logic [47:0]  xcnt3;
`endif

    mux_arb_n_to_1 #(.N(32), .M(4)) u_dut4 (
        .clk(clk), .rst(rst4), .mode(mode4), .sel(sel4),
        .in_data(idata4), .in_valid(ivalid4), .in_ready(iready4),
        .out_data(odata4), .out_valid(ovalid4), .out_ready(oready4),
        .out_src(osrc4)
`ifdef MUX_ARB_STATS_EN
        , .xfer_cnt(xcnt4)
`endif
    );

    mux_arb_n_to_1 #(.N(8), .M(3)) u_dut3 (
        .clk(clk), .rst(rst3), .mode(mode3), .sel(sel3),
        .in_data(idata3), .in_valid(ivalid3), .in_ready(iready3),
        .out_data(odata3), .out_valid(ovalid3), .out_ready(oready3),
        .out_src(osrc3)
`ifdef MUX_ARB_STATS_EN
        , .xfer_cnt(xcnt3)
`endif
    );

    localparam logic [31:0] D0 = 32'h1111_1111;
    localparam logic [31:0] D1 = 32'h2222_2222;
    localparam logic [31:0] D2 = 32'hDEAD_BEEF;
    localparam logic [31:0] D3 = 32'h4444_4444;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst4 = 1'b1; mode4 = 1'b1; sel4 = 2'd0; oready4 = 1'b1;
        idata4 = {D3, D2, D1, D0}; ivalid4 = 4'b1111;
        rst3 = 1'b1; mode3 = 1'b0; sel3 = 2'd0; oready3 = 1'b1;
        idata3 = {8'hA2, 8'hA1, 8'hA0}; ivalid3 = 3'b111;

        // Reset with all inputs valid.
        step();
        step();
        chk("rst_out_valid", {31'd0, ovalid4}, 32'd0);
        chk("rst_out_data", odata4, 32'd0);
        chk("rst_out_src", {30'd0, osrc4}, 32'd0);
        chk("rst_in_ready", {28'd0, iready4}, 32'd0);

        // Round-robin, all valid: 0,1,2,3,0,1,2,3.
        rst4 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("rr_in_ready", {28'd0, iready4}, 32'd1 << (i % 4));
            step();
            chk("rr_out_src", {30'd0, osrc4}, i % 4);
            chk("rr_out_valid", {31'd0, ovalid4}, 32'd1);
        end
        chk("rr_out_data_last", odata4, D3);

        // Directed: sel=2, all valid.
        mode4 = 1'b0; sel4 = 2'd2;
        #1;
        chk("dir_in_ready", {28'd0, iready4}, 32'h4);
        step();
        chk("dir_out_data", odata4, 32'hDEADBEEF);
        chk("dir_out_src", {30'd0, osrc4}, 32'd2);

        // Directed, selected channel not valid: slot empties, data/src hold.
        ivalid4 = 4'b1011;
        #1;
        chk("dir_nogrant_ready", {28'd0, iready4}, 32'd0);
        step();
        chk("dir_nogrant_valid", {31'd0, ovalid4}, 32'd0);
        chk("dir_nogrant_hold_data", odata4, 32'hDEADBEEF);
        chk("dir_nogrant_hold_src", {30'd0, osrc4}, 32'd2);

        // Directed transfers left rr_ptr at 3, so round-robin grants channel 0.
        mode4 = 1'b1; ivalid4 = 4'b1111;
        #1;
        chk("rr_after_dir_ready", {28'd0, iready4}, 32'h1);
        step();
        chk("rr_after_dir_src", {30'd0, osrc4}, 32'd0);

        // Back-pressure for 3 cycles with changing inputs.
        oready4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mode4 = i[0];
            sel4 = 2'(i + 1);
            ivalid4 = 4'(4'b0110 << i);
            idata4 = {D3, D2, 32'hCAFE_0000 + 32'(i), D0};
            #1;
            chk("bp_in_ready", {28'd0, iready4}, 32'd0);
            step();
            chk("bp_out_data", odata4, D0);
            chk("bp_out_src", {30'd0, osrc4}, 32'd0);
            chk("bp_out_valid", {31'd0, ovalid4}, 32'd1);
        end

        // Release: rr_ptr=0 so channel 1 loads at the same edge.
        mode4 = 1'b1; ivalid4 = 4'b1111; idata4 = {D3, D2, 32'hCAFE_F00D, D0};
        oready4 = 1'b1;
        #1;
        chk("bp_release_ready", {28'd0, iready4}, 32'h2);
        step();
        chk("bp_release_src", {30'd0, osrc4}, 32'd1);
        chk("bp_release_data", odata4, 32'hCAFEF00D);

        // Reset during a stall drops the held beat.
        oready4 = 1'b0;
        step();
        rst4 = 1'b1;
        #1;
        chk("rst_stall_ready", {28'd0, iready4}, 32'd0);
        step();
        chk("rst_stall_valid", {31'd0, ovalid4}, 32'd0);
        chk("rst_stall_data", odata4, 32'd0);

        // From reset with in_valid=1010: 1,3,1,3.
        rst4 = 1'b0; oready4 = 1'b1; mode4 = 1'b1; ivalid4 = 4'b1010;
        idata4 = {D3, D2, D1, D0};
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_1010_src", {30'd0, osrc4}, (i % 2 == 0) ? 32'd1 : 32'd3);
        end
        chk("rr_1010_data", odata4, D3);

        // M=3: directed sel=3 is out of range.
        step();
        rst3 = 1'b0; mode3 = 1'b0; sel3 = 2'd3;
        #1;
        chk("m3_sel3_ready", {29'd0, iready3}, 32'd0);
        step();
        chk("m3_sel3_valid", {31'd0, ovalid3}, 32'd0);

        // M=3 round-robin, all valid: 0,1,2,0.
        mode3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("m3_rr_src", {30'd0, osrc3}, i % 3);
            chk("m3_rr_data", {24'd0, odata3}, 32'hA0 + (i % 3));
        end

`ifdef MUX_ARB_STATS_EN
        // Counter saturation on channel 1.
        rst4 = 1'b1;
        step();
        rst4 = 1'b0; mode4 = 1'b0; sel4 = 2'd1; ivalid4 = 4'b0010; oready4 = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("cnt_ch1_5", {16'd0, xcnt4[31:16]}, 32'd5);
        for (int i = 0; i < 69995; i++) step();
        chk("cnt_ch1_sat", {16'd0, xcnt4[31:16]}, 32'hFFFF);
        chk("cnt_ch0", {16'd0, xcnt4[15:0]}, 32'd0);
        chk("cnt_ch2", {16'd0, xcnt4[47:32]}, 32'd0);
        chk("cnt_ch3", {16'd0, xcnt4[63:48]}, 32'd0);
        rst4 = 1'b1;
        step();
        chk("cnt_rst_lo", xcnt4[31:0], 32'd0);
        chk("cnt_rst_hi", xcnt4[63:32], 32'd0);
        rst4 = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
